// File: rtl/cond_exec_sequencer_if.sv
// rtl/cond_exec_sequencer_if.sv - issue/exec/flag/retire bundle for cond_exec_sequencer
// master drives instructions and datapath completion; slave is the sequencer.
interface cond_exec_sequencer_if #(
  parameter int ID_W  = 8,
  parameter int CNT_W = 16
);
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_cond;
  logic             issue_s;
  logic [ID_W-1:0]  issue_id;
  logic             exec_start;
  logic             exec_done;
  logic [3:0]       alu_flags;
  logic             flags_wr;
  logic [3:0]       flags_wdata;
  logic [3:0]       flags;
  logic             retire_valid;
  logic [ID_W-1:0]  retire_id;
  logic             retire_executed;
  logic             retire_error;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  modport master (
    output issue_valid, issue_cond, issue_s, issue_id,
    output exec_done, alu_flags, flags_wr, flags_wdata,
    input  issue_ready, exec_start, flags,
    input  retire_valid, retire_id, retire_executed, retire_error,
    input  exec_count, skip_count
  );

  modport slave (
    input  issue_valid, issue_cond, issue_s, issue_id,
    input  exec_done, alu_flags, flags_wr, flags_wdata,
    output issue_ready, exec_start, flags,
    output retire_valid, retire_id, retire_executed, retire_error,
    output exec_count, skip_count
  );
endinterface

// File: rtl/cond_exec_sequencer.sv
// rtl/cond_exec_sequencer.sv - ARM conditional-execution sequencer with NZCV register
// One instruction in flight: IDLE -> CHECK -> (EXEC) -> RETIRE, with saturating retire stats.
module cond_exec_sequencer #(
  parameter int ID_W    = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cond_exec_sequencer_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, RETIRE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cond_q;
  logic             s_q;
  logic [ID_W-1:0]  id_q;
  logic [3:0]       flags_q;
  logic [TMR_W-1:0] timer;
  logic             ret_executed;
  logic             ret_error;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  logic             accept;
  logic             cond_pass;
  logic             done_hit;
  logic             timeout_hit;
  logic             ready;
  logic             start;
  logic             n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    start       = 1'b0;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.issue_valid;
        if (bus.issue_valid) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = cond_pass ? EXEC : RETIRE;
      end
      EXEC: begin
        // timer is zero only on the first EXEC cycle of each instruction
        start = (timer == '0);
        if (bus.exec_done) begin
          done_hit  = 1'b1;
          state_nxt = RETIRE;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = RETIRE;
        end
      end
      RETIRE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cond_q       <= '0;
      s_q          <= 1'b0;
      id_q         <= '0;
      flags_q      <= '0;
      timer        <= '0;
      ret_executed <= 1'b0;
      ret_error    <= 1'b0;
      exec_cnt     <= '0;
      skip_cnt     <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        cond_q <= bus.issue_cond;
        s_q    <= bus.issue_s;
        id_q   <= bus.issue_id;
      end

      // ALU S-update outranks a simultaneous direct write
      if (done_hit && s_q) flags_q <= bus.alu_flags;
      else if (bus.flags_wr) flags_q <= bus.flags_wdata;

      if (state == EXEC && state_nxt == EXEC) timer <= timer + TMR_W'(1);
      else timer <= '0;

      if (state == CHECK && !cond_pass) begin
        ret_executed <= 1'b0;
        ret_error    <= 1'b0;
      end else if (done_hit) begin
        ret_executed <= 1'b1;
        ret_error    <= 1'b0;
      end else if (timeout_hit) begin
        ret_executed <= 1'b0;
        ret_error    <= 1'b1;
      end

      if (state == RETIRE) begin
        if (ret_executed && !(&exec_cnt)) exec_cnt <= exec_cnt + CNT_W'(1);
        if (!ret_executed && !ret_error && !(&skip_cnt)) skip_cnt <= skip_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.issue_ready     = ready;
  assign bus.exec_start      = start;
  assign bus.flags           = flags_q;
  assign bus.retire_valid    = (state == RETIRE);
  assign bus.retire_id       = id_q;
  assign bus.retire_executed = (state == RETIRE) && ret_executed;
  assign bus.retire_error    = (state == RETIRE) && ret_error;
  assign bus.exec_count      = exec_cnt;
  assign bus.skip_count      = skip_cnt;
endmodule

// File: tb/tb_cond_exec_sequencer.sv
// tb/tb_cond_exec_sequencer.sv - self-checking bench for cond_exec_sequencer
// Reference model tracks NZCV and retire counters from the condition table.
module tb_cond_exec_sequencer;
  localparam int ID_W    = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] m_flags;
  int         m_exec;
  int         m_skip;

  cond_exec_sequencer_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  cond_exec_sequencer #(.ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_cond = '0; bus.issue_s = 1'b0; bus.issue_id = '0;
    bus.exec_done = 1'b0; bus.alu_flags = '0; bus.flags_wr = 1'b0; bus.flags_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_flags = '0; m_exec = 0; m_skip = 0;
    @(negedge clk);
  endtask

  task automatic set_flags(input logic [3:0] f);
    bus.flags_wr = 1'b1; bus.flags_wdata = f;
    @(negedge clk);
    bus.flags_wr = 1'b0;
    m_flags = f;
    checks++; if (bus.flags !== f) begin failures++; $display("FAIL set_flags got=%b exp=%b", bus.flags, f); end
  endtask

  // wr_phase: 0 none, 1 issue-accept edge, 2 CHECK edge, 3 exec_done edge
  task automatic run_instr(input logic [3:0] cond, input logic s, input logic [ID_W-1:0] id,
                           input int done_at, input logic [3:0] alu, input int wr_phase, input logic [3:0] wd);
    bit pass, done, seen;
    int exp_k;
    bus.issue_valid = 1'b1; bus.issue_cond = cond; bus.issue_s = s; bus.issue_id = id;
    if (wr_phase == 1) begin bus.flags_wr = 1'b1; bus.flags_wdata = wd; end
    @(negedge clk);
    bus.issue_valid = 1'b0; bus.flags_wr = 1'b0;
    if (wr_phase == 1) m_flags = wd;
    checks++; if (bus.issue_ready !== 1'b0) begin failures++; $display("FAIL check_ready got=%b exp=0", bus.issue_ready); end
    pass = cond_ok(cond, m_flags);
    if (wr_phase == 2) begin bus.flags_wr = 1'b1; bus.flags_wdata = wd; end
    @(negedge clk);
    bus.flags_wr = 1'b0;
    if (wr_phase == 2) m_flags = wd;
    checks++; if (bus.exec_start !== pass) begin failures++; $display("FAIL exec_start cond=%b got=%b exp=%b", cond, bus.exec_start, pass); end
    checks++; if (bus.retire_valid !== !pass) begin failures++; $display("FAIL skip_retire cond=%b got=%b exp=%b", cond, bus.retire_valid, !pass); end
    done  = pass && done_at >= 0 && done_at < TIMEOUT;
    exp_k = done ? done_at : TIMEOUT - 1;
    seen  = !pass;
    if (pass) begin
      for (int k = 0; k < TIMEOUT + 4 && !seen; k++) begin
        if (k == done_at) begin
          bus.exec_done = 1'b1; bus.alu_flags = alu;
          if (wr_phase == 3) begin bus.flags_wr = 1'b1; bus.flags_wdata = wd; end
        end
        @(negedge clk);
        bus.exec_done = 1'b0; bus.flags_wr = 1'b0;
        if (bus.retire_valid === 1'b1) begin
          seen = 1'b1;
          checks++; if (k != exp_k) begin failures++; $display("FAIL retire_latency got=%0d exp=%0d", k, exp_k); end
        end else begin
          checks++; if (bus.exec_start !== 1'b0) begin failures++; $display("FAIL exec_start_late k=%0d got=%b exp=0", k, bus.exec_start); end
        end
      end
    end
    if (!seen) begin
      failures++; checks++;
      $display("FAIL retire_missing got=none exp=retire");
    end else begin
      checks++; if (bus.retire_id !== id) begin failures++; $display("FAIL retire_id got=%h exp=%h", bus.retire_id, id); end
      checks++; if (bus.retire_executed !== done) begin failures++; $display("FAIL retire_executed got=%b exp=%b", bus.retire_executed, done); end
      checks++; if (bus.retire_error !== (pass && !done)) begin failures++; $display("FAIL retire_error got=%b exp=%b", bus.retire_error, pass && !done); end
    end
    if (done) begin
      if (wr_phase == 3) m_flags = wd;
      if (s) m_flags = alu;
      if (m_exec < MAXC) m_exec++;
    end
    if (!pass && m_skip < MAXC) m_skip++;
    @(negedge clk);
    checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", bus.issue_ready); end
    checks++; if (bus.retire_valid !== 1'b0) begin failures++; $display("FAIL retire_once got=%b exp=0", bus.retire_valid); end
    checks++; if (bus.flags !== m_flags) begin failures++; $display("FAIL flags got=%b exp=%b", bus.flags, m_flags); end
    checks++; if (bus.exec_count !== CNT_W'(m_exec)) begin failures++; $display("FAIL exec_count got=%0d exp=%0d", bus.exec_count, m_exec); end
    checks++; if (bus.skip_count !== CNT_W'(m_skip)) begin failures++; $display("FAIL skip_count got=%0d exp=%0d", bus.skip_count, m_skip); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
    checks++; if (bus.exec_count !== '0 || bus.skip_count !== '0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.exec_count, bus.skip_count); end
    checks++; if ({bus.exec_start, bus.retire_valid, bus.retire_executed, bus.retire_error} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {bus.exec_start, bus.retire_valid, bus.retire_executed, bus.retire_error}); end
    checks++; if (bus.retire_id !== '0) begin failures++; $display("FAIL reset_id got=%h exp=00", bus.retire_id); end
    checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.issue_ready); end
  endtask

  task automatic test_basic();
    run_instr(4'b0001, 1'b1, 8'd5, 0, 4'b0100, 0, 4'b0);
    checks++; if (bus.flags !== 4'b0100) begin failures++; $display("FAIL basic_flags got=%b exp=0100", bus.flags); end
    run_instr(4'b0001, 1'b1, 8'd6, 0, 4'b1111, 0, 4'b0);
    checks++; if (bus.skip_count !== 4'd1) begin failures++; $display("FAIL basic_skip got=%0d exp=1", bus.skip_count); end
  endtask

  task automatic test_sweep();
    do_reset();
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) begin
        set_flags(4'(f));
        run_instr(4'(c), 1'b0, 8'(c * 16 + f), 0, 4'b0, 0, 4'b0);
      end
  endtask

  task automatic test_timeout();
    logic [CNT_W-1:0] e0, s0;
    do_reset();
    set_flags(4'b1010);
    e0 = bus.exec_count; s0 = bus.skip_count;
    run_instr(4'b1110, 1'b1, 8'hA5, -1, 4'b0, 0, 4'b0);
    checks++; if (bus.exec_count !== e0 || bus.skip_count !== s0) begin failures++; $display("FAIL timeout_counts got=%0d/%0d exp=%0d/%0d", bus.exec_count, bus.skip_count, e0, s0); end
    bus.exec_done = 1'b1; bus.alu_flags = 4'b0101;
    @(negedge clk);
    bus.exec_done = 1'b0;
    repeat (2) begin
      checks++; if (bus.retire_valid !== 1'b0 || bus.flags !== 4'b1010) begin failures++; $display("FAIL late_done got=%b/%b exp=0/1010", bus.retire_valid, bus.flags); end
      @(negedge clk);
    end
  endtask

  task automatic test_flag_priority();
    set_flags(4'b0000);
    run_instr(4'b1110, 1'b1, 8'h11, 2, 4'b0010, 3, 4'b1001);
    checks++; if (bus.flags !== 4'b0010) begin failures++; $display("FAIL alu_wins got=%b exp=0010", bus.flags); end
    set_flags(4'b0000);
    run_instr(4'b0000, 1'b0, 8'h12, 0, 4'b0, 1, 4'b0100);
    set_flags(4'b0000);
    run_instr(4'b0000, 1'b0, 8'h13, 0, 4'b0, 2, 4'b0100);
    checks++; if (bus.flags !== 4'b0100 || bus.skip_count !== CNT_W'(m_skip)) begin failures++; $display("FAIL check_write got=%b exp=0100", bus.flags); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(4'b1110, 1'b0, 8'(i), 1, 4'b0, 0, 4'b0);
    checks++; if (bus.exec_count !== 4'd15) begin failures++; $display("FAIL exec_saturate got=%0d exp=15", bus.exec_count); end
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 80; i++) begin
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 1));
      run_instr(4'($urandom), 1'($urandom), 8'($urandom), d, 4'($urandom),
                int'($urandom_range(0, 3)), 4'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1'b1; bus.issue_cond = 4'b1110; bus.issue_s = 1'b1; bus.issue_id = 8'h77;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.exec_start !== 1'b1) begin failures++; $display("FAIL mid_exec got=%b exp=1", bus.exec_start); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({bus.exec_start, bus.retire_valid, bus.retire_executed, bus.retire_error} !== 4'b0) begin failures++; $display("FAIL mid_pulses got=%b exp=0000", {bus.exec_start, bus.retire_valid, bus.retire_executed, bus.retire_error}); end
    checks++; if (bus.flags !== 4'b0 || bus.exec_count !== '0 || bus.skip_count !== '0 || bus.retire_id !== '0) begin failures++; $display("FAIL mid_state got=%b/%0d/%0d/%h exp=0", bus.flags, bus.exec_count, bus.skip_count, bus.retire_id); end
    checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", bus.issue_ready); end
    bus.exec_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.exec_done = 1'b0;
      checks++; if (bus.retire_valid !== 1'b0) begin failures++; $display("FAIL mid_noretire got=%b exp=0", bus.retire_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_timeout();
    test_flag_priority();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
